// File: rtl/cpu_send_pkg.sv
// Shared types and the round-robin pick helper for the CPU send arbiter.
// Widths used by the helper are sized for the largest supported port count.
package cpu_send_pkg;

    localparam int N_CPU_DEF  = 4;
    localparam int DATA_W_DEF = 64;
    localparam int MAX_CPU    = 32;
    localparam int MAX_IDX_W  = 5;

    typedef logic [$clog2(N_CPU_DEF)-1:0] cpu_idx_t;
    typedef logic [DATA_W_DEF-1:0]        data_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    // First set bit of req at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAX_CPU-1:0] req,
                                      input int unsigned        ptr,
                                      input int unsigned        n);
        pick_t       r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < MAX_CPU; k++) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) j = j - n;
                if (!r.found && req[j[MAX_IDX_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[MAX_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cpu_send_if.sv
// Producer/consumer bus of the CPU send arbiter; slave is the arbiter side.
interface cpu_send_if #(
    parameter int N_CPU  = cpu_send_pkg::N_CPU_DEF,
    parameter int DATA_W = cpu_send_pkg::DATA_W_DEF,
    parameter int CNT_W  = 16
);
    localparam int IDX_W = $clog2(N_CPU);

    logic [N_CPU-1:0]        in_vld;
    logic [N_CPU*DATA_W-1:0] in_data;
    logic [N_CPU-1:0]        in_done;
    logic                    out_vld;
    logic [DATA_W-1:0]       out_data;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_rdy;
    logic                    all_done;
    logic [N_CPU*CNT_W-1:0]  drop_cnt;

    modport master (
        output in_vld, in_data, in_done, out_rdy,
        input  out_vld, out_data, out_idx, all_done, drop_cnt
    );

    modport slave (
        input  in_vld, in_data, in_done, out_rdy,
        output out_vld, out_data, out_idx, all_done, drop_cnt
    );
endinterface

// File: rtl/cpu_send_fifo.sv
// Per-producer synchronous FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate flag.
module cpu_send_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  count_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, rptr_q;
    logic         push_ok, pop_ok;

    assign count_o = wptr_q - rptr_q;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (count_o == '0);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop_ok)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/cpu_send_arbiter.sv
// Shares one send channel between N_CPU fire-and-forget producers: per-port
// FIFOs, round-robin grant into a single output slot, and global done tracking.
module cpu_send_arbiter
    import cpu_send_pkg::*;
#(
    parameter int N_CPU      = N_CPU_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input logic       clk,
    input logic       rst,
    cpu_send_if.slave bus
);

    localparam int IDX_W = $clog2(N_CPU);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic [N_CPU-1:0]  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_dout [N_CPU];
    logic [CW-1:0]     fifo_cnt  [N_CPU];
    logic [CNT_W-1:0]  drop_q    [N_CPU];

    for (genvar i = 0; i < N_CPU; i++) begin : g_port
        // Full comes from the registered count, so a same-cycle pop never makes room.
        assign fifo_push[i] = bus.in_vld[i] & ~fifo_full[i];

        cpu_send_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (fifo_push[i]),
            .pop_i   (fifo_pop[i]),
            .din_i   (bus.in_data[i*DATA_W +: DATA_W]),
            .dout_o  (fifo_dout[i]),
            .full_o  (fifo_full[i]),
            .empty_o (fifo_empty[i]),
            .count_o (fifo_cnt[i])
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                drop_q[i] <= '0;
            end else if (bus.in_vld[i] && fifo_full[i] && drop_q[i] != '1) begin
                drop_q[i] <= drop_q[i] + CNT_W'(1);
            end
        end

        assign bus.drop_cnt[i*CNT_W +: CNT_W] = drop_q[i];
    end

    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_CPU-1:0]  done_seen_q, done_seen_d;
    logic              all_done_q, all_done_d;
    logic              load, drained;
    logic [IDX_W-1:0]  grant;
    pick_t             pick;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        load        = ~out_vld_q | bus.out_rdy;
        pick        = rr_pick(MAX_CPU'(~fifo_empty), 32'(rr_ptr_q), N_CPU);
        grant       = pick.idx[IDX_W-1:0];
        fifo_pop    = '0;
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        rr_ptr_d    = rr_ptr_q;
        drained     = 1'b1;
        for (int i = 0; i < N_CPU; i++) begin
            if (fifo_cnt[i] != '0) drained = 1'b0;
        end

        if (load) begin
            if (pick.found) begin
                out_vld_d       = 1'b1;
                out_data_d      = fifo_dout[grant];
                out_idx_d       = grant;
                fifo_pop[grant] = 1'b1;
                rr_ptr_d        = (grant == IDX_W'(N_CPU-1)) ? '0 : grant + IDX_W'(1);
            end else begin
                out_vld_d = 1'b0;
            end
        end

        done_seen_d = done_seen_q | bus.in_done;
        all_done_d  = all_done_q | (&done_seen_q & drained & ~out_vld_q);
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            rr_ptr_q    <= '0;
            done_seen_q <= '0;
            all_done_q  <= 1'b0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            done_seen_q <= done_seen_d;
            all_done_q  <= all_done_d;
        end
    end

    assign bus.out_vld  = out_vld_q;
    assign bus.out_data = out_data_q;
    assign bus.out_idx  = out_idx_q;
    assign bus.all_done = all_done_q;

endmodule
